// File: rtl/apb_fsm_controller.sv
// ---------------------------------------------------------------------------
// apb_fsm_controller
//
// Purpose:
//   APB-side sequencer of an AHB-to-APB bridge. Takes transfer requests from
//   the AHB slave interface and walks them through the APB phases
//   (IDLE -> [WWAIT] -> SETUP -> ACCESS). It stalls the AHB master with
//   hreadyout while an APB transfer is in progress.
//
// Optional feature macro:
//   APB_PREADY_EN : if defined, ACCESS is extended until pready=1. All APB
//                   outputs and hreadyout=0 are held while waiting.
//                   If undefined, pready is ignored and ACCESS lasts 1 cycle.
//
// Ports:
//   hclk       in   clock, all state changes on the rising edge
//   hresetn    in   asynchronous active-low reset
//   valid      in   qualified AHB transfer request (address phase)
//   hwrite     in   request direction, 1 = write
//   haddr      in   request address (address phase)
//   hwdata     in   write data (AHB data phase, one cycle after the address)
//   prdata     in   read data from the APB slaves
//   pready     in   APB slave ready (used only with APB_PREADY_EN)
//   pselx      out  one-hot APB slave select (registered)
//   penable    out  APB access-phase strobe (registered)
//   pwrite     out  APB direction (registered)
//   paddr      out  APB address (registered)
//   pwdata     out  APB write data (registered)
//   hrdata     out  read data to AHB, combinational copy of prdata
//   hreadyout  out  AHB ready; 0 stalls the AHB master
// ---------------------------------------------------------------------------
module apb_fsm_controller #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [ADDR_W-1:0] SLV2_BASE = 32'h8800_0000
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic [2:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WWAIT  = 2'd1,
    S_SETUP  = 2'd2,
    S_ACCESS = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_pselx,   w_pselx_next;
  logic                r_penable, w_penable_next;
  logic                r_pwrite,  w_pwrite_next;
  logic [ADDR_W-1:0]   r_paddr,   w_paddr_next;
  logic [DATA_W-1:0]   r_pwdata,  w_pwdata_next;
  logic                w_complete;
  logic                w_accept;
  logic                w_hreadyout;

  // Each slave owns a 64 MB window, so only the top 6 address bits decode.
  function automatic logic [2:0] f_decode(input logic [5:0] top);
    logic [2:0] sel;
    sel = 3'b000;
    if (top == SLV0_BASE[ADDR_W-1 -: 6]) sel = 3'b001;
    if (top == SLV1_BASE[ADDR_W-1 -: 6]) sel = 3'b010;
    if (top == SLV2_BASE[ADDR_W-1 -: 6]) sel = 3'b100;
    return sel;
  endfunction

`ifdef APB_PREADY_EN
  assign w_complete = pready;
`else
  assign w_complete = 1'b1;
  logic w_unused_pready;
  assign w_unused_pready = pready;
`endif

  // A new request is only sampled while the AHB side sees hreadyout=1.
  assign w_accept = valid & ((r_state == S_IDLE) |
                             ((r_state == S_ACCESS) & w_complete));

  always_comb begin
    w_state_next   = r_state;
    w_pselx_next   = r_pselx;
    w_penable_next = r_penable;
    w_pwrite_next  = r_pwrite;
    w_paddr_next   = r_paddr;
    w_pwdata_next  = r_pwdata;
    w_hreadyout    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_hreadyout = 1'b1;
      end
      S_WWAIT: begin
        // Write data arrives one cycle after the address on AHB.
        w_pwdata_next = hwdata;
        w_pselx_next  = f_decode(r_paddr[ADDR_W-1 -: 6]);
        w_state_next  = S_SETUP;
      end
      S_SETUP: begin
        w_penable_next = 1'b1;
        w_state_next   = S_ACCESS;
      end
      S_ACCESS: begin
        // Without completion everything simply holds (defaults above).
        if (w_complete) begin
          w_hreadyout    = 1'b1;
          w_state_next   = S_IDLE;
          w_pselx_next   = 3'b000;
          w_penable_next = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Shared by IDLE and a completing ACCESS: back-to-back transfers skip IDLE.
    if (w_accept) begin
      w_paddr_next   = haddr;
      w_pwrite_next  = hwrite;
      w_penable_next = 1'b0;
      if (hwrite) begin
        w_state_next = S_WWAIT;
        w_pselx_next = 3'b000;
      end else begin
        w_state_next = S_SETUP;
        w_pselx_next = f_decode(haddr[ADDR_W-1 -: 6]);
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state   <= S_IDLE;
      r_pselx   <= 3'b000;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pselx   <= w_pselx_next;
      r_penable <= w_penable_next;
      r_pwrite  <= w_pwrite_next;
      r_paddr   <= w_paddr_next;
      r_pwdata  <= w_pwdata_next;
    end
  end

  assign pselx     = r_pselx;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign hrdata    = prdata;
  assign hreadyout = w_hreadyout;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// ---------------------------------------------------------------------------
// tb_apb_fsm_controller
//
// Directed bench for apb_fsm_controller. Inputs change and outputs are
// sampled 1 ns after each rising clock edge. Expected values are written
// out by hand for each cycle of each transfer.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] hrdata;
  logic        hreadyout;

  int n_checks = 0;
  int n_errors = 0;

  apb_fsm_controller dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hrdata    (hrdata),
    .hreadyout (hreadyout)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Checks select, strobe and AHB ready for the current cycle.
  task automatic check_phase(input string tag, input logic [2:0] sel,
                             input logic en, input logic rdy);
    check({tag, ".pselx"},     {29'd0, pselx},     {29'd0, sel});
    check({tag, ".penable"},   {31'd0, penable},   {31'd0, en});
    check({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, rdy});
  endtask

  task automatic request(input logic wr, input logic [31:0] addr);
    valid  = 1'b1;
    hwrite = wr;
    haddr  = addr;
  endtask

  initial begin
    hresetn = 1'b0;
    valid   = 1'b0;
    hwrite  = 1'b0;
    haddr   = 32'h0;
    hwdata  = 32'h0;
    prdata  = 32'h0;
    pready  = 1'b1;

    // ---------------- reset state ----------------
    #12;
    check_phase("rst", 3'b000, 1'b0, 1'b1);
    check("rst.paddr",  paddr,  32'h0);
    check("rst.pwdata", pwdata, 32'h0);
    check("rst.pwrite", {31'd0, pwrite}, 32'd0);
    hresetn = 1'b1;
    tick();
    $display("reset released");

    // ---------------- 1: read slave 0 ----------------
    prdata = 32'h1234_5678;
    request(1'b0, 32'h8000_0010);
    check("t1.idle.hreadyout", {31'd0, hreadyout}, 32'd1);
    tick();                                   // SETUP
    valid = 1'b0;
    check_phase("t1.setup", 3'b001, 1'b0, 1'b0);
    check("t1.setup.paddr", paddr, 32'h8000_0010);
    check("t1.setup.pwrite", {31'd0, pwrite}, 32'd0);
    tick();                                   // ACCESS
    check_phase("t1.access", 3'b001, 1'b1, 1'b1);
    check("t1.access.hrdata", hrdata, 32'h1234_5678);
    tick();                                   // IDLE
    check_phase("t1.idle", 3'b000, 1'b0, 1'b1);
    $display("t1 read 0x80000010 done");

    // ---------------- 2: write slave 1 ----------------
    request(1'b1, 32'h8400_0004);
    tick();                                   // WWAIT
    valid  = 1'b0;
    hwdata = 32'hDEAD_BEEF;
    check_phase("t2.wwait", 3'b000, 1'b0, 1'b0);
    check("t2.wwait.pwrite", {31'd0, pwrite}, 32'd1);
    tick();                                   // SETUP
    hwdata = 32'h0;
    check_phase("t2.setup", 3'b010, 1'b0, 1'b0);
    check("t2.setup.pwdata", pwdata, 32'hDEAD_BEEF);
    check("t2.setup.paddr",  paddr,  32'h8400_0004);
    tick();                                   // ACCESS
    check_phase("t2.access", 3'b010, 1'b1, 1'b1);
    check("t2.access.pwdata", pwdata, 32'hDEAD_BEEF);
    check("t2.access.pwrite", {31'd0, pwrite}, 32'd1);
    tick();                                   // IDLE
    check_phase("t2.idle", 3'b000, 1'b0, 1'b1);
    $display("t2 write 0x84000004 done");

    // ---------------- 6: unmapped read ----------------
    request(1'b0, 32'h9000_0000);
    tick();                                   // SETUP
    valid = 1'b0;
    check_phase("t6.setup", 3'b000, 1'b0, 1'b0);
    check("t6.setup.pwdata_kept", pwdata, 32'hDEAD_BEEF);
    tick();                                   // ACCESS
    check_phase("t6.access", 3'b000, 1'b1, 1'b1);
    tick();                                   // IDLE
    check_phase("t6.idle", 3'b000, 1'b0, 1'b1);
    $display("t6 read 0x90000000 (unmapped) done");

    // ---------------- 3: read slave 2 then write slave 0 ----------------
    request(1'b0, 32'h8800_0000);
    tick();                                   // SETUP (read)
    request(1'b1, 32'h8000_0008);             // ignored until hreadyout=1
    check_phase("t3.rsetup", 3'b100, 1'b0, 1'b0);
    check("t3.rsetup.paddr", paddr, 32'h8800_0000);
    tick();                                   // ACCESS (read), write accepted
    check_phase("t3.raccess", 3'b100, 1'b1, 1'b1);
    check("t3.raccess.paddr", paddr, 32'h8800_0000);
    tick();                                   // WWAIT
    valid  = 1'b0;
    hwdata = 32'hCAFE_F00D;
    check_phase("t3.wwait", 3'b000, 1'b0, 1'b0);
    check("t3.wwait.paddr", paddr, 32'h8000_0008);
    tick();                                   // SETUP (write)
    check_phase("t3.wsetup", 3'b001, 1'b0, 1'b0);
    check("t3.wsetup.pwdata", pwdata, 32'hCAFE_F00D);
    tick();                                   // ACCESS (write)
    check_phase("t3.waccess", 3'b001, 1'b1, 1'b1);
    tick();                                   // IDLE
    check_phase("t3.idle", 3'b000, 1'b0, 1'b1);
    $display("t3 read 0x88000000 then write 0x80000008 done");

    // ---------------- back-to-back reads: one SETUP cycle between ----------------
    request(1'b0, 32'h8000_0020);
    tick();                                   // SETUP r1
    haddr = 32'h8400_0030;
    check_phase("bb.setup1", 3'b001, 1'b0, 1'b0);
    tick();                                   // ACCESS r1, r2 accepted
    check_phase("bb.access1", 3'b001, 1'b1, 1'b1);
    check("bb.access1.paddr", paddr, 32'h8000_0020);
    tick();                                   // SETUP r2
    valid = 1'b0;
    check_phase("bb.setup2", 3'b010, 1'b0, 1'b0);
    check("bb.setup2.paddr", paddr, 32'h8400_0030);
    tick();                                   // ACCESS r2
    check_phase("bb.access2", 3'b010, 1'b1, 1'b1);
    tick();
    check_phase("bb.idle", 3'b000, 1'b0, 1'b1);
    $display("back-to-back reads 0x80000020, 0x84000030 done");

    // ---------------- 5: pready wait states ----------------
    request(1'b0, 32'h8000_0040);
    tick();                                   // SETUP
    valid  = 1'b0;
    pready = 1'b0;
    check_phase("t5.setup", 3'b001, 1'b0, 1'b0);
    tick();                                   // ACCESS cycle 1
`ifdef APB_PREADY_EN
    check_phase("t5.access1", 3'b001, 1'b1, 1'b0);
    tick();                                   // ACCESS cycle 2
    check_phase("t5.access2", 3'b001, 1'b1, 1'b0);
    check("t5.access2.paddr", paddr, 32'h8000_0040);
    pready = 1'b1;
    #1;
    check_phase("t5.access3", 3'b001, 1'b1, 1'b1);
    tick();
    check_phase("t5.idle", 3'b000, 1'b0, 1'b1);
    $display("t5 read with 2 wait states done");
`else
    // pready ignored: ACCESS lasts one cycle even with pready low.
    check_phase("t5.access", 3'b001, 1'b1, 1'b1);
    tick();
    check_phase("t5.idle", 3'b000, 1'b0, 1'b1);
    pready = 1'b1;
    $display("t5 read with pready low (ignored) done");
`endif

    // ---------------- 4: async reset during write ACCESS ----------------
    request(1'b1, 32'h8400_0010);
    tick();                                   // WWAIT
    valid  = 1'b0;
    hwdata = 32'h5555_AAAA;
    tick();                                   // SETUP
    tick();                                   // ACCESS
    check_phase("t4.access", 3'b010, 1'b1, 1'b1);
    #2;
    hresetn = 1'b0;
    #1;
    check_phase("t4.inreset", 3'b000, 1'b0, 1'b1);
    check("t4.inreset.paddr", paddr, 32'h0);
    #2;
    hresetn = 1'b1;
    tick();
    check_phase("t4.after", 3'b000, 1'b0, 1'b1);
    check("t4.after.pwrite", {31'd0, pwrite}, 32'd0);
    $display("t4 reset during write access done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
